rect_fill: RTL and testbench

Solid-rectangle fill sequencer that sits directly upstream of `line_fill`. It accepts one rectangle command (origin, size, colour, frame base address) and clips it to the frame. It then issues one horizontal-line request per row to `line_fill` over a valid/ready handshake. It signals completion once the last line has been fully written.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/rect_fill.sv | 142 ++++++++++++++
 tb/tb_rect_fill.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared frame-buffer fill definitions: coordinate type,
//                rect_fill sequencer states, frame-geometry defaults and the
//                pixel size shared with line_fill.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  typedef logic [15:0] coord_t;

  localparam int IMG_WIDTH     = 1920;
  localparam int IMG_HEIGHT    = 1080;
  localparam int BYTES_PER_PIX = 4;

  typedef enum logic [2:0] {
    RF_IDLE  = 3'd0,
    RF_CLIP  = 3'd1,
    RF_EMIT  = 3'd2,
    RF_FLUSH = 3'd3,
    RF_DONE  = 3'd4
  } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : rect_fill
//  Description : Solid-rectangle fill sequencer. Accepts one rectangle
//                command, clips it to the frame in a single registered stage,
//                then issues one horizontal-line request per row to line_fill
//                over valid/ready and pulses done once the final line's
//                writes have completed.
//  Ports       : clk, rstn (sync, active-low)
//                req_*   : rectangle command in (valid/ready)
//                line_*  : line request out to line_fill (valid/ready)
//                busy    : command in flight, done : completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_fill
  import fb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int IMG_WIDTH      = fb_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT     = fb_pkg::IMG_HEIGHT,
  parameter int PIX_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [AXI_ADDR_WIDTH-1:0] req_base_addr,
  input  coord_t                    req_x,
  input  coord_t                    req_y,
  input  coord_t                    req_w,
  input  coord_t                    req_h,
  input  logic [PIX_WIDTH-1:0]      req_color,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic [AXI_ADDR_WIDTH-1:0] line_base_addr,
  output coord_t                    line_x,
  output coord_t                    line_y,
  output coord_t                    line_w,
  output logic [PIX_WIDTH-1:0]      line_color,
  output logic                      line_valid,
  input  logic                      line_ready,
  output logic                      busy,
  output logic                      done
);

  localparam logic [16:0] c_img_w = 17'(IMG_WIDTH);
  localparam logic [16:0] c_img_h = 17'(IMG_HEIGHT);

  rf_state_t   r_state;
  rf_state_t   w_state_nxt;
  logic        r_req_ready;
  logic        r_flush_armed;
  coord_t      r_w;
  coord_t      r_h;
  logic [16:0] r_ye;

  logic [16:0] w_x_sum;
  logic [16:0] w_y_sum;
  logic [16:0] w_xe;
  logic [16:0] w_ye;
  logic        w_empty;
  logic        w_last_line;
  logic        w_accept;

  // 17-bit sums so x+w / y+h can never wrap before clipping.
  assign w_x_sum     = {1'b0, line_x} + {1'b0, r_w};
  assign w_y_sum     = {1'b0, line_y} + {1'b0, r_h};
  assign w_xe        = (w_x_sum > c_img_w) ? c_img_w : w_x_sum;
  assign w_ye        = (w_y_sum > c_img_h) ? c_img_h : w_y_sum;
  assign w_empty     = ({1'b0, line_x} >= c_img_w) || ({1'b0, line_y} >= c_img_h) ||
                       (r_w == '0) || (r_h == '0);
  assign w_last_line = (({1'b0, line_y} + 17'd1) == r_ye);
  assign w_accept    = req_valid && r_req_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= RF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RF_IDLE:  if (w_accept) w_state_nxt = RF_CLIP;
      RF_CLIP:  w_state_nxt = w_empty ? RF_DONE : RF_EMIT;
      RF_EMIT:  if (line_ready && w_last_line) w_state_nxt = RF_FLUSH;
      // The entry cycle still sees line_fill's ready from before it took the
      // last line, so completion is only trusted once the flag is armed.
      RF_FLUSH: if (r_flush_armed && line_ready) w_state_nxt = RF_DONE;
      RF_DONE:  w_state_nxt = RF_IDLE;
      default:  w_state_nxt = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_req_ready    <= 1'b0;
      r_flush_armed  <= 1'b0;
      r_w            <= '0;
      r_h            <= '0;
      r_ye           <= '0;
      line_base_addr <= '0;
      line_x         <= '0;
      line_y         <= '0;
      line_w         <= '0;
      line_color     <= '0;
    end else begin
      // Registered ready: low for the first cycle out of reset, high in IDLE.
      r_req_ready   <= (w_state_nxt == RF_IDLE);
      r_flush_armed <= (r_state == RF_FLUSH);
      case (r_state)
        RF_IDLE: begin
          if (w_accept) begin
            line_base_addr <= req_base_addr;
            line_x         <= req_x;
            line_y         <= req_y;
            line_color     <= req_color;
            r_w            <= req_w;
            r_h            <= req_h;
          end
        end
        RF_CLIP: begin
          line_w <= coord_t'(w_xe - {1'b0, line_x});
          r_ye   <= w_ye;
        end
        RF_EMIT: begin
          if (line_ready && !w_last_line) begin
            line_y <= line_y + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign line_valid = (r_state == RF_EMIT);
  assign busy       = (r_state != RF_IDLE);
  assign done       = (r_state == RF_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_fill
//  Description : Self-checking bench for rect_fill. A small line_fill
//                stand-in drives line_ready (drops for a configurable number
//                of cycles after each accepted line); observed line requests
//                are compared against a row-by-row rectangle clip model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rect_fill;

  localparam int AW = 32;
  localparam int PW = 32;
  localparam int W  = 1920;
  localparam int H  = 1080;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] req_base_addr;
  logic [15:0]   req_x, req_y, req_w, req_h;
  logic [PW-1:0] req_color;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] line_base_addr;
  logic [15:0]   line_x, line_y, line_w;
  logic [PW-1:0] line_color;
  logic          line_valid;
  logic          line_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  rect_fill #(
    .AXI_ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_WIDTH(PW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_base_addr(req_base_addr), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_color(req_color),
    .req_valid(req_valid), .req_ready(req_ready),
    .line_base_addr(line_base_addr), .line_x(line_x), .line_y(line_y),
    .line_w(line_w), .line_color(line_color),
    .line_valid(line_valid), .line_ready(line_ready),
    .busy(busy), .done(done)
  );

  typedef struct {
    int          x;
    int          y;
    int          w;
    logic [31:0] color;
    logic [31:0] base;
  } line_t;

  line_t got_q[$];
  line_t exp_q[$];

  int cyc, lf_cnt, lf_lat;
  int n_checks, n_fail;
  int n_unstable, n_rdy_bad, n_done, n_acc, n_valid_cycles;
  int last_done_cyc, last_hs_cyc, last_acc_cyc, first_valid_cyc;
  bit in_cmd;

  // One clock: sample handshakes on stable pre-edge values, then update the
  // line_fill stand-in and the monitors 1 ns after the edge.
  task automatic tick();
    bit    acc, hs, hold, rst_now;
    line_t snap;
    acc     = rstn && req_valid && req_ready;
    hs      = rstn && line_valid && line_ready;
    hold    = rstn && line_valid && !line_ready;
    snap    = '{int'(line_x), int'(line_y), int'(line_w), line_color, line_base_addr};
    rst_now = !rstn;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_now) begin
      in_cmd = 1'b0;
      lf_cnt = 0;
    end else begin
      if (hs) begin
        got_q.push_back(snap);
        last_hs_cyc = cyc - 1;
        lf_cnt = lf_lat;
      end else if (lf_cnt > 0) begin
        lf_cnt--;
      end
      if (acc) begin
        in_cmd = 1'b1;
        last_acc_cyc = cyc - 1;
        n_acc++;
      end
    end
    line_ready = (lf_cnt == 0);
    if (hold && !(line_valid && int'(line_x) == snap.x && int'(line_y) == snap.y &&
                  int'(line_w) == snap.w && line_color == snap.color &&
                  line_base_addr == snap.base))
      n_unstable++;
    if (line_valid) begin
      n_valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (in_cmd && req_ready) n_rdy_bad++;
    if (done) begin
      n_done++;
      last_done_cyc = cyc;
      in_cmd = 1'b0;
    end
  endtask

  // Reference: one line per visible row, width clipped at the right edge.
  function automatic void model_rect(input int x, input int y, input int w, input int h,
                                     input logic [31:0] color, input logic [31:0] base);
    int xe, ye;
    if (w == 0 || h == 0 || x >= W || y >= H) return;
    xe = (x + w > W) ? W : x + w;
    ye = (y + h > H) ? H : y + h;
    for (int r = y; r < ye; r++) exp_q.push_back('{x, r, xe - x, color, base});
  endfunction

  function automatic int count_diff();
    int n;
    n = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].w != exp_q[i].w ||
          got_q[i].color != exp_q[i].color || got_q[i].base != exp_q[i].base)
        n++;
    return n;
  endfunction

  function automatic void clear_obs();
    got_q.delete();
    exp_q.delete();
    first_valid_cyc = -1;
    n_done = 0;
    n_valid_cycles = 0;
    n_unstable = 0;
    n_rdy_bad = 0;
  endfunction

  task automatic drive_req(input int x, input int y, input int w, input int h,
                           input logic [31:0] color, input logic [31:0] base);
    req_x = 16'(x); req_y = 16'(y); req_w = 16'(w); req_h = 16'(h);
    req_color = color; req_base_addr = base;
  endtask

  // Issue one command and run it to its done pulse (bounded), scrambling the
  // request inputs after acceptance to show they are ignored.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input logic [31:0] color, input logic [31:0] base,
                         output bit timed_out);
    int k;
    clear_obs();
    drive_req(x, y, w, h, color, base);
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    tick();
    req_valid = 1'b0;
    drive_req(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              $urandom, $urandom);
    k = 0;
    while (n_done == 0 && k < 2000) begin tick(); k++; end
    timed_out = (n_done == 0);
    tick();
    tick();
    model_rect(x, y, w, h, color, base);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_checks++;
    if (req_ready !== 1'b0 || line_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b lv=%b busy=%b done=%b want all 0",
               req_ready, line_valid, busy, done);
    end
    n_checks++;
    if ({line_x, line_y, line_w} !== 48'd0 || line_color !== '0 || line_base_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got x=%0d y=%0d w=%0d c=%h b=%h want 0",
               line_x, line_y, line_w, line_color, line_base_addr);
    end
    rstn = 1'b1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_ready: got %b want 0", req_ready);
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    bit to;
    lf_lat = 3;
    run_cmd(10, 20, 100, 3, 32'hCAFE_0001, 32'h1000_0000, to);
    n_checks++;
    if (to || count_diff() != 0 || got_q.size() != 3) begin
      n_fail++;
      $display("FAIL basic_lines: got %0d lines (%0d diffs, timeout=%0b) want 3",
               got_q.size(), count_diff(), to);
    end
    n_checks++;
    if (n_done !== 1) begin
      n_fail++;
      $display("FAIL basic_done_count: got %0d want 1", n_done);
    end
    n_checks++;
    if (first_valid_cyc - last_acc_cyc !== 2) begin
      n_fail++;
      $display("FAIL basic_first_latency: got %0d want 2", first_valid_cyc - last_acc_cyc);
    end
    n_checks++;
    if (last_done_cyc - last_hs_cyc !== 5 || n_rdy_bad !== 0) begin
      n_fail++;
      $display("FAIL basic_done_timing: got %0d (rdy_bad=%0d) want 5 (0)",
               last_done_cyc - last_hs_cyc, n_rdy_bad);
    end
  endtask

  task automatic test_clip();
    bit to;
    int xs[3] = '{1900, 1820, 100};
    int ws[3] = '{100, 100, 65535};
    int ys[3] = '{1078, 500, 7};
    int hs[3] = '{10, 2, 1};
    int nl[3] = '{2, 2, 1};
    lf_lat = 1;
    for (int i = 0; i < 3; i++) begin
      run_cmd(xs[i], ys[i], ws[i], hs[i], 32'h00FF_0000 + i, 32'h2000_0000, to);
      n_checks++;
      if (to || count_diff() != 0 || got_q.size() != nl[i]) begin
        n_fail++;
        $display("FAIL clip_%0d: got %0d lines w=%0d (%0d diffs) want %0d lines w=%0d",
                 i, got_q.size(), (got_q.size() > 0) ? got_q[0].w : -1, count_diff(),
                 nl[i], (exp_q.size() > 0) ? exp_q[0].w : -1);
      end
    end
  endtask

  task automatic test_empty();
    bit to;
    int xs[4] = '{5, 5, 1920, 5};
    int ys[4] = '{5, 5, 5, 5000};
    int ws[4] = '{0, 10, 10, 10};
    int hs[4] = '{3, 0, 3, 3};
    lf_lat = 2;
    for (int i = 0; i < 4; i++) begin
      run_cmd(xs[i], ys[i], ws[i], hs[i], 32'h1234_5678, 32'h3000_0000, to);
      n_checks++;
      if (to || n_valid_cycles != 0 || n_done != 1 || last_done_cyc - last_acc_cyc != 2) begin
        n_fail++;
        $display("FAIL empty_%0d: got valid_cycles=%0d done=%0d latency=%0d want 0, 1, 2",
                 i, n_valid_cycles, n_done, last_done_cyc - last_acc_cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    lf_lat = 7;
    run_cmd(300, 400, 64, 4, 32'hA5A5_A5A5, 32'h4000_0000, to);
    n_checks++;
    if (to || count_diff() != 0) begin
      n_fail++;
      $display("FAIL bp_lines: got %0d lines (%0d diffs) want 4", got_q.size(), count_diff());
    end
    n_checks++;
    if (n_unstable !== 0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable cycles want 0", n_unstable);
    end
    n_checks++;
    if (last_done_cyc - last_hs_cyc !== 9) begin
      n_fail++;
      $display("FAIL bp_done_after_ready: got %0d want 9", last_done_cyc - last_hs_cyc);
    end
  endtask

  task automatic test_reset_mid_emit();
    bit to;
    int k;
    lf_lat = 2;
    clear_obs();
    drive_req(50, 100, 30, 5, 32'h0BAD_F00D, 32'h5000_0000);
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    tick();
    req_valid = 1'b0;
    k = 0;
    while (got_q.size() < 2 && k < 200) begin tick(); k++; end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_checks++;
    if (line_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || got_q.size() != 2) begin
      n_fail++;
      $display("FAIL mid_reset: got lv=%b busy=%b done=%b lines=%0d want 0 0 0 2",
               line_valid, busy, done, got_q.size());
    end
    run_cmd(7, 9, 11, 3, 32'h7777_0000, 32'h6000_0000, to);
    n_checks++;
    if (to || count_diff() != 0 || n_done != 1) begin
      n_fail++;
      $display("FAIL mid_reset_recover: got %0d lines done=%0d (%0d diffs) want 3 lines, 1",
               got_q.size(), n_done, count_diff());
    end
  endtask

  task automatic test_back_to_back();
    int k, acc0, d1;
    lf_lat = 1;
    clear_obs();
    drive_req(1, 2, 3, 2, 32'h1111_1111, 32'h7000_0000);
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    tick();
    drive_req(1910, 1079, 40, 6, 32'h2222_2222, 32'h7100_0000);
    k = 0;
    while (n_done == 0 && k < 500) begin tick(); k++; end
    d1 = last_done_cyc;
    acc0 = n_acc;
    k = 0;
    while (n_acc == acc0 && k < 50) begin tick(); k++; end
    n_checks++;
    if (last_acc_cyc - d1 !== 1) begin
      n_fail++;
      $display("FAIL b2b_accept_gap: got %0d want 1", last_acc_cyc - d1);
    end
    req_valid = 1'b0;
    k = 0;
    while (n_done < 2 && k < 500) begin tick(); k++; end
    model_rect(1, 2, 3, 2, 32'h1111_1111, 32'h7000_0000);
    model_rect(1910, 1079, 40, 6, 32'h2222_2222, 32'h7100_0000);
    n_checks++;
    if (count_diff() != 0 || n_done != 2) begin
      n_fail++;
      $display("FAIL b2b_lines: got %0d lines done=%0d (%0d diffs) want 3 lines, 2",
               got_q.size(), n_done, count_diff());
    end
    n_checks++;
    if (n_rdy_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_ready_low: got %0d busy cycles with ready want 0", n_rdy_bad);
    end
  endtask

  task automatic test_random();
    bit to;
    int x, y, w, h, lat;
    for (int i = 0; i < 20; i++) begin
      x   = int'($urandom_range(0, 2000));
      y   = int'($urandom_range(0, 1100));
      w   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 300));
      h   = int'($urandom_range(0, 12));
      lat = int'($urandom_range(0, 4));
      lf_lat = lat;
      run_cmd(x, y, w, h, $urandom, $urandom, to);
      n_checks++;
      if (to || count_diff() != 0 || n_done != 1 || n_unstable != 0 || n_rdy_bad != 0) begin
        n_fail++;
        $display("FAIL rand_%0d (x=%0d y=%0d w=%0d h=%0d): got %0d lines done=%0d diffs=%0d unstable=%0d want %0d lines, 1, 0, 0",
                 i, x, y, w, h, got_q.size(), n_done, count_diff(), n_unstable, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        if (last_done_cyc - last_hs_cyc != ((lat > 0) ? lat : 1) + 2 ||
            first_valid_cyc - last_acc_cyc != 2) begin
          n_fail++;
          $display("FAIL rand_timing_%0d: got done gap %0d first %0d want %0d and 2", i,
                   last_done_cyc - last_hs_cyc, first_valid_cyc - last_acc_cyc,
                   ((lat > 0) ? lat : 1) + 2);
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0;
    line_ready = 1'b1;
    drive_req(0, 0, 0, 0, 32'd0, 32'd0);
    cyc = 0; lf_cnt = 0; lf_lat = 0;
    n_checks = 0; n_fail = 0; n_acc = 0;
    in_cmd = 1'b0;
    last_done_cyc = 0; last_hs_cyc = 0; last_acc_cyc = 0;
    clear_obs();
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_backpressure();
    test_reset_mid_emit();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test by 5 ms want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
